// File: rtl/cpu_pipe_pkg.sv
// Shared CPU pipeline definitions: instruction width, bubble encoding, per-stage payload layouts.
// Used by pipe_stage_reg (optional skid entry: PIPE_STAGE_SKID_EN).
package cpu_pipe_pkg;

  localparam int          INST_W   = 32;
  localparam logic [31:0] NOP_INST = 32'hFF000000;

  localparam int IFID_DATA_W  = 32;
  localparam int IDEX_DATA_W  = 156;
  localparam int EXMEM_DATA_W = 134;
  localparam int MEMWB_DATA_W = 69;

  typedef struct packed {
    logic [31:0] pc4;
  } ifid_data_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [22:0] ctrl;
  } idex_data_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [31:0] branch_tgt;
    logic [4:0]  rd;
    logic        mem_we;
  } exmem_data_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [31:0] pc4;
    logic [4:0]  rd;
  } memwb_data_t;

  // What the main entry does on the coming edge.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_FLUSH,
    ACT_LOAD,
    ACT_DRAIN,
    ACT_PROMOTE
  } stage_act_e;

  function automatic logic is_bubble(input logic [INST_W-1:0] inst);
    return inst == NOP_INST;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream handshake bundle of one pipeline stage register.
// master = the hazard unit / neighbouring stages, slave = the stage register itself.
interface pipe_stage_reg_if #(
  parameter int INST_W = 32,
  parameter int DATA_W = 96
) ();

  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] in_inst;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_inst, in_data, flush, out_ready,
    input  in_ready, out_valid, out_inst, out_data
  );

  modport slave (
    input  in_valid, in_inst, in_data, flush, out_ready,
    output in_ready, out_valid, out_inst, out_data
  );

endinterface

// File: rtl/pipe_skid_slot.sv
// Single valid+data holding register with clear-over-load priority; the skid entry
// of pipe_stage_reg, only built when PIPE_STAGE_SKID_EN is defined.
`ifdef PIPE_STAGE_SKID_EN
module pipe_skid_slot #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         valid_reg;
  logic [W-1:0] q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      q_reg     <= '0;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      q_reg     <= d;
    end
  end

  assign valid = valid_reg;
  assign q     = q_reg;

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: valid/ready handshake, flush, NOP bubbles, saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry and register in_ready.
module pipe_stage_reg #(
  parameter int                INST_W   = cpu_pipe_pkg::INST_W,
  parameter int                DATA_W   = 96,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(cpu_pipe_pkg::NOP_INST),
  parameter int                CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_stage_reg_if.slave  bus,
  output logic [CNT_W-1:0] stall_cnt
);

  import cpu_pipe_pkg::*;

  logic              main_valid_reg;
  logic [INST_W-1:0] main_inst_reg;
  logic [DATA_W-1:0] main_data_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;

  logic       load;
  logic       drain;
  logic       stalled;
  stage_act_e act;

  assign load    = bus.in_valid & bus.in_ready;
  assign drain   = main_valid_reg & bus.out_ready;
  assign stalled = main_valid_reg & ~bus.out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic                     skid_valid;
  logic [INST_W+DATA_W-1:0] skid_q;
  logic                     skid_load;
  logic                     skid_clear;

  // The skid slot is the only thing that can refuse input, so ready comes straight off a flop.
  assign bus.in_ready = ~skid_valid;
  assign skid_load    = load & stalled & ~bus.flush;
  assign skid_clear   = bus.flush | (drain & skid_valid);

  pipe_skid_slot #(
    .W (INST_W + DATA_W)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .clear (skid_clear),
    .d     ({bus.in_inst, bus.in_data}),
    .valid (skid_valid),
    .q     (skid_q)
  );
`else
  assign bus.in_ready = ~main_valid_reg | bus.out_ready;
`endif

  // A skid word is older than anything on the input, so it wins the main entry on drain.
  always_comb begin
    act = ACT_HOLD;
    if (bus.flush) begin
      act = ACT_FLUSH;
    end
`ifdef PIPE_STAGE_SKID_EN
    else if (drain & skid_valid) begin
      act = ACT_PROMOTE;
    end
`endif
    else if (load & (~main_valid_reg | bus.out_ready)) begin
      act = ACT_LOAD;
    end else if (drain) begin
      act = ACT_DRAIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_reg <= 1'b0;
      main_inst_reg  <= NOP_INST;
      main_data_reg  <= '0;
    end else begin
      case (act)
        ACT_FLUSH, ACT_DRAIN: begin
          main_valid_reg <= 1'b0;
          main_inst_reg  <= NOP_INST;
        end
        ACT_LOAD: begin
          main_valid_reg <= 1'b1;
          main_inst_reg  <= bus.in_inst;
          main_data_reg  <= bus.in_data;
        end
`ifdef PIPE_STAGE_SKID_EN
        ACT_PROMOTE: begin
          main_valid_reg <= 1'b1;
          {main_inst_reg, main_data_reg} <= skid_q;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // Counts every backpressured cycle, flush or not, and sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (stalled && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign bus.out_valid = main_valid_reg;
  assign bus.out_inst  = main_inst_reg;
  assign bus.out_data  = main_data_reg;
  assign stall_cnt     = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a queue-based occupancy model
// (PIPE_STAGE_SKID_EN selects capacity 2 and registered ready).
module tb_pipe_stage_reg;

  localparam int          INST_W  = 32;
  localparam int          DATA_W  = 96;
  localparam int          CNT_W   = 4;
  localparam logic [31:0] NOP     = 32'hFF000000;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CNT_W-1:0] stall_cnt;

  pipe_stage_reg_if #(.INST_W(INST_W), .DATA_W(DATA_W)) bus ();

  pipe_stage_reg #(
    .INST_W   (INST_W),
    .DATA_W   (DATA_W),
    .NOP_INST (NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the stage is a FIFO of held words; front is what out_* shows.
  logic [INST_W-1:0] mq_inst[$];
  logic [DATA_W-1:0] mq_data[$];
  logic [DATA_W-1:0] m_last = '0;
  int                m_cnt  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready(input logic ordy);
`ifdef PIPE_STAGE_SKID_EN
    return mq_inst.size() < 2;
`else
    return (mq_inst.size() == 0) || ordy;
`endif
  endfunction

  task automatic check_outputs(input string tag);
    logic          ev;
    logic [31:0]   ei;
    logic [95:0]   ed;
    ev = mq_inst.size() > 0;
    ei = ev ? mq_inst[0] : NOP;
    ed = ev ? mq_data[0] : m_last;
    chk({tag, ".out_valid"}, 128'(bus.out_valid), 128'(ev));
    chk({tag, ".out_inst"},  128'(bus.out_inst),  128'(ei));
    chk({tag, ".out_data"},  128'(bus.out_data),  128'(ed));
    chk({tag, ".stall_cnt"}, 128'(stall_cnt),     128'(m_cnt));
  endtask

  task automatic model_reset();
    mq_inst.delete();
    mq_data.delete();
    m_last = '0;
    m_cnt  = 0;
  endtask

  task automatic cycle(input string tag, input logic v, input logic [31:0] inst,
                       input logic [95:0] data, input logic fl, input logic ordy);
    logic        exp_rdy;
    logic [31:0] di;
    logic [95:0] dd;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_inst   = inst;
    bus.in_data   = data;
    bus.flush     = fl;
    bus.out_ready = ordy;
    #1;
    exp_rdy = model_ready(ordy);
    chk({tag, ".in_ready"}, 128'(bus.in_ready), 128'(exp_rdy));
    if (mq_inst.size() > 0 && !ordy && m_cnt < CNT_MAX) m_cnt++;
    if (fl) begin
      mq_inst.delete();
      mq_data.delete();
    end else begin
      if (mq_inst.size() > 0 && ordy) begin
        di = mq_inst.pop_front();
        dd = mq_data.pop_front();
      end
      if (v && exp_rdy) begin
        mq_inst.push_back(inst);
        mq_data.push_back(data);
      end
    end
    if (mq_inst.size() > 0) m_last = mq_data[0];
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  function automatic logic [95:0] rnd96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_inst   = '0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset release
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("reset.in_ready", 128'(bus.in_ready), 128'(1'b1));
    chk("reset.out_inst_const", 128'(bus.out_inst), 128'(32'hFF000000));
    check_outputs("reset");
    $display("txn reset_release out_valid=%0b out_inst=%0h", bus.out_valid, bus.out_inst);

    // Streaming 1..4 at full throughput, then drain to a bubble
    for (int i = 1; i <= 4; i++) begin
      cycle($sformatf("stream%0d", i), 1'b1, 32'(i), rnd96(), 1'b0, 1'b1);
      chk($sformatf("stream%0d.const", i), 128'(bus.out_inst), 128'(i));
      $display("txn stream inst=%0h out_inst=%0h", i, bus.out_inst);
    end
    cycle("stream_end", 1'b0, '0, '0, 1'b0, 1'b1);
    chk("stream_end.nop", 128'(bus.out_inst), 128'(32'hFF000000));
    $display("txn stream_end out_valid=%0b out_inst=%0h", bus.out_valid, bus.out_inst);

    // Stall: 0xAB held for 5 backpressured cycles while upstream keeps offering
    cycle("stall_load", 1'b1, 32'h000000AB, rnd96(), 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle($sformatf("stall%0d", i), 1'b1, 32'h00000100 + 32'(i), rnd96(), 1'b0, 1'b0);
      $display("txn stall cyc=%0d out_inst=%0h in_ready=%0b cnt=%0d",
               i, bus.out_inst, bus.in_ready, stall_cnt);
    end
    chk("stall.hold_ab", 128'(bus.out_inst), 128'(32'h000000AB));
    chk("stall.cnt5", 128'(stall_cnt), 128'(5));
    for (int i = 0; i < 3; i++) begin
      cycle($sformatf("unstall%0d", i), 1'b0, '0, '0, 1'b0, 1'b1);
      $display("txn unstall out_valid=%0b out_inst=%0h", bus.out_valid, bus.out_inst);
    end

    // Flush with a simultaneous load: 0x55 must never surface
    cycle("flush_pre", 1'b1, 32'h00000077, rnd96(), 1'b0, 1'b1);
    cycle("flush", 1'b1, 32'h00000055, rnd96(), 1'b1, 1'b0);
    chk("flush.valid", 128'(bus.out_valid), 128'(1'b0));
    chk("flush.nop", 128'(bus.out_inst), 128'(32'hFF000000));
    $display("txn flush out_valid=%0b out_inst=%0h", bus.out_valid, bus.out_inst);
    for (int i = 0; i < 3; i++) begin
      cycle($sformatf("flush_multi%0d", i), 1'b1, 32'h00000200 + 32'(i), rnd96(), 1'b1, 1'b0);
      $display("txn flush_multi out_valid=%0b", bus.out_valid);
    end
    cycle("flush_after", 1'b0, '0, '0, 1'b0, 1'b1);
    chk("flush_after.no55", 128'(bus.out_inst == 32'h00000055), 128'(1'b0));

`ifdef PIPE_STAGE_SKID_EN
    // Skid: 0x20 taken while 0x10 is stalled, order kept, then flush clears both
    cycle("skid_main", 1'b1, 32'h00000010, rnd96(), 1'b0, 1'b0);
    cycle("skid_fill", 1'b1, 32'h00000020, rnd96(), 1'b0, 1'b0);
    chk("skid_fill.rdy0", 128'(bus.in_ready), 128'(1'b0));
    cycle("skid_out1", 1'b0, '0, '0, 1'b0, 1'b1);
    chk("skid_out1.const", 128'(bus.out_inst), 128'(32'h00000020));
    $display("txn skid_order out_inst=%0h", bus.out_inst);
    cycle("skid_out2", 1'b0, '0, '0, 1'b0, 1'b1);
    cycle("skid_refill1", 1'b1, 32'h00000030, rnd96(), 1'b0, 1'b0);
    cycle("skid_refill2", 1'b1, 32'h00000040, rnd96(), 1'b0, 1'b0);
    cycle("skid_flush", 1'b0, '0, '0, 1'b1, 1'b0);
    cycle("skid_after_flush", 1'b0, '0, '0, 1'b0, 1'b1);
    chk("skid_flush.empty", 128'(bus.out_valid), 128'(1'b0));
    $display("txn skid_flush out_valid=%0b in_ready=%0b", bus.out_valid, bus.in_ready);
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 150; i++) begin
      cycle($sformatf("rnd%0d", i), $urandom_range(0, 3) != 0, $urandom(), rnd96(),
            $urandom_range(0, 15) == 0, $urandom_range(0, 9) < 6);
      $display("txn rnd%0d out_valid=%0b out_inst=%0h cnt=%0d",
               i, bus.out_valid, bus.out_inst, stall_cnt);
    end

    // Asynchronous reset in the middle of a stall
    cycle("areset_load", 1'b1, 32'h000000CD, rnd96(), 1'b0, 1'b1);
    cycle("areset_stall", 1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("areset");
    $display("txn async_reset out_valid=%0b out_inst=%0h cnt=%0d",
             bus.out_valid, bus.out_inst, stall_cnt);
    @(negedge clk);
    rst_n = 1'b1;

    // Counter saturation: 20 stalled cycles on a 4-bit counter
    cycle("sat_load", 1'b1, 32'h000000EE, rnd96(), 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cycle($sformatf("sat%0d", i), 1'b0, '0, '0, 1'b0, 1'b0);
    end
    chk("sat.cnt15", 128'(stall_cnt), 128'(15));
    $display("txn saturate cnt=%0d", stall_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
